// File: rtl/vga_pattern_module_if.sv
// Pixel-stage bundle between the VGA sync generator, the pattern stage and the DAC side.
//   master : drives sync/ready/address/Mode_Next and observes the delayed sync, RGB, mode
//            and frame tick (the sync generator / testbench side).
//   slave  : the pattern stage itself.
interface vga_pattern_module_if;
  logic        HSYNC_Sig;
  logic        VSYNC_Sig;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [10:0] Row_Addr_Sig;
  logic        Mode_Next;
  logic        HSYNC_Out;
  logic        VSYNC_Out;
  logic        Red_Sig;
  logic        Green_Sig;
  logic        Blue_Sig;
  logic [1:0]  Mode_Sig;
  logic        Frame_Tick;

  modport master (
    output HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Mode_Next,
    input  HSYNC_Out, VSYNC_Out, Red_Sig, Green_Sig, Blue_Sig, Mode_Sig, Frame_Tick
  );

  modport slave (
    input  HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Mode_Next,
    output HSYNC_Out, VSYNC_Out, Red_Sig, Green_Sig, Blue_Sig, Mode_Sig, Frame_Tick
  );
endinterface

// File: rtl/vga_pattern_module.sv
// VGA test-pattern pixel stage. Takes sync/ready/column/row from the sync generator and
// produces 1-bit RGB test patterns (colour bars, grid, bouncing box, solid white), with
// HSYNC/VSYNC delayed two cycles to stay aligned with the pixels. Mode steps only on a
// VSYNC rising edge so frames never tear.
// Ports:
//   CLK  : pixel clock
//   RST  : synchronous reset, active-high
//   pix  : slave modport of vga_pattern_module_if (inputs from sync generator, RGB,
//          delayed syncs, Mode_Sig and Frame_Tick out)
module vga_pattern_module #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned BAR_W      = 100,
  parameter int unsigned GRID_SHIFT = 5,
  parameter int unsigned BOX_SIZE   = 64,
  parameter int unsigned BOX_STEP   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  vga_pattern_module_if.slave  pix
);

  localparam logic [11:0] XMax = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] YMax = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Step = 12'(BOX_STEP);
  localparam logic [11:0] Size = 12'(BOX_SIZE);

  typedef enum logic [1:0] {StBars = 2'd0, StGrid = 2'd1, StBox = 2'd2, StSolid = 2'd3} mode_e;

  // Stage 1
  logic        hs1_q, vs1_q, rdy1_q;
  logic [10:0] col1_q, row1_q;
  // Stage 2 / registered outputs
  logic        hs2_q, vs2_q;
  logic [2:0]  rgb_q, rgb_d;
  mode_e       mode_q, mode_d;
  logic        pending_q, pending_d;
  logic        vsync_prev_q;
  logic        frame_tick_q;
  logic        tick;
  // Box state; dir 1 = moving towards MAX
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]  bar_idx;
  logic        in_box;

  assign tick = pix.VSYNC_Sig & ~vsync_prev_q;

  // Mode stepping: requests are collapsed into one step per frame boundary.
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q | pix.Mode_Next;
    if (tick && pending_d) begin
      mode_d    = mode_e'(mode_q + 2'd1);
      pending_d = 1'b0;
    end
  end

  // Box bounce, X and Y independent, clamped to 0..MAX.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (tick) begin
      if (dir_x_q) begin
        if ({1'b0, box_x_q} + Step >= XMax) begin
          box_x_d = XMax[10:0];
          dir_x_d = 1'b0;
        end else begin
          box_x_d = box_x_q + Step[10:0];
        end
      end else if ({1'b0, box_x_q} <= Step) begin
        box_x_d = '0;
        dir_x_d = 1'b1;
      end else begin
        box_x_d = box_x_q - Step[10:0];
      end
      if (dir_y_q) begin
        if ({1'b0, box_y_q} + Step >= YMax) begin
          box_y_d = YMax[10:0];
          dir_y_d = 1'b0;
        end else begin
          box_y_d = box_y_q + Step[10:0];
        end
      end else if ({1'b0, box_y_q} <= Step) begin
        box_y_d = '0;
        dir_y_d = 1'b1;
      end else begin
        box_y_d = box_y_q - Step[10:0];
      end
    end
  end

  // Bar index by compare chain; anything past the 7th boundary is bar 7.
  always_comb begin
    bar_idx = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      if ({1'b0, col1_q} < 12'(BAR_W * k)) bar_idx = 3'(k - 1);
    end
  end

  assign in_box = (col1_q >= box_x_q) && ({1'b0, col1_q} < {1'b0, box_x_q} + Size) &&
                  (row1_q >= box_y_q) && ({1'b0, row1_q} < {1'b0, box_y_q} + Size);

  always_comb begin
    rgb_d = 3'b000;
    if (rdy1_q) begin
      unique case (mode_q)
        StBars:  rgb_d = ~bar_idx;
        StGrid:  rgb_d = ((col1_q[GRID_SHIFT-1:0] == '0) || (row1_q[GRID_SHIFT-1:0] == '0)) ?
                         3'b111 : 3'b000;
        StBox:   rgb_d = in_box ? 3'b111 : 3'b001;
        StSolid: rgb_d = 3'b111;
        default: rgb_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      rdy1_q       <= 1'b0;
      col1_q       <= '0;
      row1_q       <= '0;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
      rgb_q        <= 3'b000;
      mode_q       <= StBars;
      pending_q    <= 1'b0;
      vsync_prev_q <= 1'b1;
      frame_tick_q <= 1'b0;
      box_x_q      <= '0;
      box_y_q      <= '0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
    end else begin
      hs1_q        <= pix.HSYNC_Sig;
      vs1_q        <= pix.VSYNC_Sig;
      rdy1_q       <= pix.Ready_Sig;
      col1_q       <= pix.Column_Addr_Sig;
      row1_q       <= pix.Row_Addr_Sig;
      hs2_q        <= hs1_q;
      vs2_q        <= vs1_q;
      rgb_q        <= rgb_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      vsync_prev_q <= pix.VSYNC_Sig;
      frame_tick_q <= tick;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
    end
  end

  assign pix.HSYNC_Out  = hs2_q;
  assign pix.VSYNC_Out  = vs2_q;
  assign pix.Red_Sig    = rgb_q[2];
  assign pix.Green_Sig  = rgb_q[1];
  assign pix.Blue_Sig   = rgb_q[0];
  assign pix.Mode_Sig   = mode_q;
  assign pix.Frame_Tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_module.sv
module tb_vga_pattern_module;
  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  vga_pattern_module_if vif ();

  vga_pattern_module dut (
    .CLK (CLK),
    .RST (RST),
    .pix (vif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [2:0] rgb_now();
    return {vif.Red_Sig, vif.Green_Sig, vif.Blue_Sig};
  endfunction

  task automatic idle_inputs();
    vif.HSYNC_Sig       = 1'b1;
    vif.VSYNC_Sig       = 1'b1;
    vif.Ready_Sig       = 1'b0;
    vif.Column_Addr_Sig = '0;
    vif.Row_Addr_Sig    = '0;
    vif.Mode_Next       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One frame boundary: VSYNC low for a cycle, then high; returns #1 after the tick edge.
  task automatic frame();
    @(negedge CLK);
    vif.Ready_Sig = 1'b0;
    vif.VSYNC_Sig = 1'b0;
    @(negedge CLK);
    vif.VSYNC_Sig = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic step_mode();
    @(negedge CLK);
    vif.Mode_Next = 1'b1;
    @(negedge CLK);
    vif.Mode_Next = 1'b0;
    frame();
  endtask

  // Present one pixel and return the RGB that appears two edges later.
  task automatic probe(input logic rdy, input int c, input int r, output logic [2:0] rgb);
    @(negedge CLK);
    vif.Ready_Sig       = rdy;
    vif.Column_Addr_Sig = 11'(c);
    vif.Row_Addr_Sig    = 11'(r);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    rgb = rgb_now();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (vif.HSYNC_Out !== 1'b1 || vif.VSYNC_Out !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync got hs=%b vs=%b want 1 1", vif.HSYNC_Out, vif.VSYNC_Out);
    end
    checks++;
    if (rgb_now() !== 3'b000) begin
      failures++;
      $display("FAIL reset_rgb got %b want 000", rgb_now());
    end
    checks++;
    if (vif.Mode_Sig !== 2'd0) begin
      failures++;
      $display("FAIL reset_mode got %0d want 0", vif.Mode_Sig);
    end
    checks++;
    if (vif.Frame_Tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got %b want 0", vif.Frame_Tick);
    end
  endtask

  task automatic test_bars();
    int          cols [7] = '{0, 99, 100, 150, 699, 700, 799};
    logic [2:0]  exp  [7] = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b001, 3'b000, 3'b000};
    logic [2:0]  got;
    for (int i = 0; i < 7; i++) begin
      probe(1'b1, cols[i], 10, got);
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL bars_col%0d got %b want %b", cols[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_grid();
    logic [2:0] got;
    int         c   [4] = '{32, 5, 5, 64};
    int         r   [4] = '{5, 5, 64, 63};
    logic [2:0] exp [4] = '{3'b111, 3'b000, 3'b111, 3'b111};
    step_mode();
    checks++;
    if (vif.Mode_Sig !== 2'd1) begin
      failures++;
      $display("FAIL grid_mode got %0d want 1", vif.Mode_Sig);
    end
    for (int i = 0; i < 4; i++) begin
      probe(1'b1, c[i], r[i], got);
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL grid_%0d_%0d got %b want %b", c[i], r[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_mode_step();
    do_reset();
    repeat (2) begin
      @(negedge CLK);
      vif.Mode_Next = 1'b1;
      @(negedge CLK);
      vif.Mode_Next = 1'b0;
    end
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (vif.Mode_Sig !== 2'd0) begin
      failures++;
      $display("FAIL mode_hold got %0d want 0", vif.Mode_Sig);
    end
    frame();
    checks++;
    if (vif.Mode_Sig !== 2'd1 || vif.Frame_Tick !== 1'b1) begin
      failures++;
      $display("FAIL mode_step got mode=%0d tick=%b want 1 1", vif.Mode_Sig, vif.Frame_Tick);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (vif.Frame_Tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_width got %b want 0", vif.Frame_Tick);
    end
    frame();
    checks++;
    if (vif.Mode_Sig !== 2'd1) begin
      failures++;
      $display("FAIL mode_nostep got %0d want 1", vif.Mode_Sig);
    end
    // Request on the very cycle of the VSYNC rise.
    @(negedge CLK);
    vif.VSYNC_Sig = 1'b0;
    @(negedge CLK);
    vif.VSYNC_Sig = 1'b1;
    vif.Mode_Next = 1'b1;
    @(posedge CLK);
    #1;
    vif.Mode_Next = 1'b0;
    checks++;
    if (vif.Mode_Sig !== 2'd2) begin
      failures++;
      $display("FAIL mode_same_cycle got %0d want 2", vif.Mode_Sig);
    end
  endtask

  task automatic test_solid_ready();
    logic [2:0] got;
    do_reset();
    repeat (3) step_mode();
    checks++;
    if (vif.Mode_Sig !== 2'd3) begin
      failures++;
      $display("FAIL solid_mode got %0d want 3", vif.Mode_Sig);
    end
    probe(1'b0, 123, 45, got);
    checks++;
    if (got !== 3'b000) begin
      failures++;
      $display("FAIL solid_notready got %b want 000", got);
    end
    probe(1'b1, 123, 45, got);
    checks++;
    if (got !== 3'b111) begin
      failures++;
      $display("FAIL solid_ready got %b want 111", got);
    end
    @(negedge CLK);
    vif.HSYNC_Sig = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (vif.HSYNC_Out !== 1'b1) begin
      failures++;
      $display("FAIL hsync_lag1 got %b want 1", vif.HSYNC_Out);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (vif.HSYNC_Out !== 1'b0) begin
      failures++;
      $display("FAIL hsync_lag2 got %b want 0", vif.HSYNC_Out);
    end
    @(negedge CLK);
    vif.HSYNC_Sig = 1'b1;
  endtask

  // Box checks: in_c/in_r inside (white), out_c/out_r outside (blue).
  task automatic check_box(input string tag, input int bx, input int by);
    logic [2:0] got;
    int         c   [5];
    int         r   [5];
    logic [2:0] exp [5];
    c = '{bx, bx + 63, bx - 1, bx, bx + 64};
    r = '{by, by + 63, by, by - 1, by};
    exp = '{3'b111, 3'b111, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 5; i++) begin
      if (c[i] >= 0 && c[i] < 800 && r[i] >= 0 && r[i] < 600) begin
        probe(1'b1, c[i], r[i], got);
        checks++;
        if (got !== exp[i]) begin
          failures++;
          $display("FAIL box_%s_%0d_%0d got %b want %b", tag, c[i], r[i], got, exp[i]);
        end
      end
    end
  endtask

  task automatic test_box();
    do_reset();
    step_mode();
    step_mode();
    checks++;
    if (vif.Mode_Sig !== 2'd2) begin
      failures++;
      $display("FAIL box_mode got %0d want 2", vif.Mode_Sig);
    end
    check_box("t2", 8, 8);
    repeat (132) frame();
    check_box("t134", 536, 536);
    repeat (50) frame();
    check_box("t184", 736, 336);
    frame();
    check_box("t185", 732, 332);
  endtask

  task automatic test_reset_midframe();
    logic [2:0] got;
    @(negedge CLK);
    vif.Ready_Sig = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (vif.Mode_Sig !== 2'd0 || rgb_now() !== 3'b000) begin
      failures++;
      $display("FAIL midreset got mode=%0d rgb=%b want 0 000", vif.Mode_Sig, rgb_now());
    end
    @(negedge CLK);
    RST = 1'b0;
    probe(1'b1, 150, 0, got);
    checks++;
    if (got !== 3'b110) begin
      failures++;
      $display("FAIL midreset_refill got %b want 110", got);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    idle_inputs();
    test_reset();
    test_bars();
    test_grid();
    test_mode_step();
    test_solid_ready();
    test_box();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
